input_conditioner: RTL

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 72 +++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Debounces Channels key/switch inputs: polarity fix, 2-flop sync, per-channel stability counter.
// o_level changes StableCycles+1 edges after the raw change is first sampled; no backpressure.
module input_conditioner #(
    parameter int Channels     = 4,
    parameter int StableCycles = 500000,
    parameter bit ActiveLow    = 1'b1
) (
    input  logic                i_clock_50mhz,
    input  logic                i_reset,
    input  logic [Channels-1:0] i_raw,
    output logic [Channels-1:0] o_level,
    output logic [Channels-1:0] o_press,
    output logic [Channels-1:0] o_release
);

    localparam int              CntW    = $clog2(StableCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(StableCycles - 1);

    logic [Channels-1:0] logical_in;
    logic [Channels-1:0] sync_meta;
    logic [Channels-1:0] sync;

    assign logical_in = i_raw ^ {Channels{ActiveLow}};

    always_ff @(posedge i_clock_50mhz or negedge i_reset) begin
        if (!i_reset) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= logical_in;
            sync      <= sync_meta;
        end
    end

    for (genvar ch = 0; ch < Channels; ch++) begin : g_chan
        logic [CntW-1:0] cnt;
        logic            level_q;
        logic            press_q;
        logic            rel_q;
        logic            mismatch;
        logic            expire;

        // A mismatch that survives StableCycles consecutive edges commits the new level.
        assign mismatch = sync[ch] ^ level_q;
        assign expire   = mismatch && (cnt == CntLast);

        always_ff @(posedge i_clock_50mhz or negedge i_reset) begin
            if (!i_reset) begin
                cnt     <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= expire & ~level_q;
                rel_q   <= expire & level_q;
                if (!mismatch || expire) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                if (expire) begin
                    level_q <= ~level_q;
                end
            end
        end

        assign o_level[ch]   = level_q;
        assign o_press[ch]   = press_q;
        assign o_release[ch] = rel_q;
    end

endmodule
